// File: rtl/jtag_dbg_pkg.sv
// Shared definitions for the debug-side GPR access path: DMI op codes and addresses,
// abstract-command field positions, cmderr codes and FSM states.
package jtag_dbg_pkg;

    localparam logic [1:0] OpNop   = 2'd0;
    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;
    localparam logic [1:0] OpRsvd  = 2'd3;

    localparam int unsigned AddrData0      = 'h04;
    localparam int unsigned AddrAbstractcs = 'h16;
    localparam int unsigned AddrCommand    = 'h17;

    localparam int unsigned CmdTypeLsb  = 24;
    localparam int unsigned CmdTypeMsb  = 31;
    localparam int unsigned AarsizeLsb  = 20;
    localparam int unsigned AarsizeMsb  = 22;
    localparam int unsigned TransferBit = 17;
    localparam int unsigned WriteBit    = 16;
    localparam int unsigned RegnoMsb    = 15;
    localparam logic [2:0]  Aarsize32   = 3'd2;

    localparam int unsigned AbscsBusyBit   = 12;
    localparam int unsigned AbscsCmderrLsb = 8;
    localparam int unsigned AbscsCmderrMsb = 10;
    localparam logic [3:0]  DataCount      = 4'd1;

    typedef enum logic [2:0] {
        CmdErrNone       = 3'd0,
        CmdErrNotSup     = 3'd2,
        CmdErrHaltResume = 3'd4
    } cmderr_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

endpackage

// File: rtl/jtag_abs_cmd_decode.sv
// Combinational decode of an "access register" abstract command into a GPR access
// decision and the resulting cmderr value.
module jtag_abs_cmd_decode
    import jtag_dbg_pkg::*;
#(
    parameter int unsigned GPR_NUM    = 32,
    parameter logic [15:0] REGNO_BASE = 16'h1000,
    localparam int unsigned IdxW      = $clog2(GPR_NUM)
) (
    input  logic [31:0]     i_command,
    input  logic            i_halted,
    input  logic [2:0]      i_cmderr,
    output logic            o_do_access,
    output logic            o_is_write,
    output logic [IdxW-1:0] o_gpr_index,
    output logic [2:0]      o_new_cmderr
);

    logic [16:0] w_offset;
    logic        w_in_range;
    logic        w_transfer;
    logic        w_notsup;

    // 17-bit subtraction: bit 16 set means regno is below the base.
    assign w_offset   = {1'b0, i_command[RegnoMsb:0]} - {1'b0, REGNO_BASE};
    assign w_in_range = !w_offset[16] && (w_offset < 17'(GPR_NUM));
    assign w_transfer = i_command[TransferBit];
    assign w_notsup   = (i_command[CmdTypeMsb:CmdTypeLsb] != 8'd0)
                     || (i_command[AarsizeMsb:AarsizeLsb] != Aarsize32)
                     || (w_transfer && !w_in_range);

    assign o_is_write  = i_command[WriteBit];
    assign o_gpr_index = w_offset[IdxW-1:0];

    always_comb begin
        o_do_access  = 1'b0;
        o_new_cmderr = i_cmderr;
        if (i_cmderr != CmdErrNone) begin
            o_new_cmderr = i_cmderr;
        end else if (w_notsup) begin
            o_new_cmderr = CmdErrNotSup;
        end else if (!i_halted) begin
            o_new_cmderr = CmdErrHaltResume;
        end else if (w_transfer) begin
            o_do_access = 1'b1;
        end
    end

endmodule

// File: rtl/jtag_gpr_access.sv
// DMI-facing debug initiator: holds DATA0/ABSTRACTCS/COMMAND and runs register-access
// abstract commands against the register file's debug port.
module jtag_gpr_access
    import jtag_dbg_pkg::*;
#(
    parameter int unsigned DMI_ADDR_W = 6,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned GPR_NUM    = 32,
    parameter logic [15:0] REGNO_BASE = 16'h1000,
    localparam int unsigned IdxW      = $clog2(GPR_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DMI_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    input  logic                  halted_i,
    output logic                  gpr_we_o,
    output logic [IdxW-1:0]       gpr_addr_o,
    output logic [DATA_W-1:0]     gpr_wdata_o,
    input  logic [DATA_W-1:0]     gpr_rdata_i
);

    state_e            r_state, w_state_d;
    logic [DATA_W-1:0] r_data0, w_data0_d;
    logic [2:0]        r_cmderr, w_cmderr_d;
    logic              r_busy, w_busy_d;
    logic              r_is_write, w_is_write_d;
    logic [IdxW-1:0]   r_gpr_idx, w_gpr_idx_d;
    logic [DATA_W-1:0] r_resp_rdata, w_resp_rdata_d;
    logic              r_resp_err, w_resp_err_d;

    logic              w_do_access;
    logic              w_dec_write;
    logic [IdxW-1:0]   w_dec_idx;
    logic [2:0]        w_new_cmderr;
    logic [DATA_W-1:0] w_abscs;
    logic              w_is_data0, w_is_abscs, w_is_cmd;

    jtag_abs_cmd_decode #(
        .GPR_NUM    (GPR_NUM),
        .REGNO_BASE (REGNO_BASE)
    ) u_decode (
        .i_command    (req_wdata[31:0]),
        .i_halted     (halted_i),
        .i_cmderr     (r_cmderr),
        .o_do_access  (w_do_access),
        .o_is_write   (w_dec_write),
        .o_gpr_index  (w_dec_idx),
        .o_new_cmderr (w_new_cmderr)
    );

    assign w_is_data0 = (req_addr == DMI_ADDR_W'(AddrData0));
    assign w_is_abscs = (req_addr == DMI_ADDR_W'(AddrAbstractcs));
    assign w_is_cmd   = (req_addr == DMI_ADDR_W'(AddrCommand));

    always_comb begin
        w_abscs = '0;
        w_abscs[AbscsBusyBit]                  = r_busy;
        w_abscs[AbscsCmderrMsb:AbscsCmderrLsb] = r_cmderr;
        w_abscs[3:0]                           = DataCount;
    end

    assign req_ready   = (r_state == StIdle);
    assign resp_valid  = (r_state == StResp);
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;
    // GPR port is driven only in ACCESS, so a reset edge ends any write immediately.
    assign gpr_we_o    = (r_state == StAccess) && r_is_write;
    assign gpr_addr_o  = (r_state == StAccess) ? r_gpr_idx : '0;
    assign gpr_wdata_o = gpr_we_o ? r_data0 : '0;

    always_comb begin
        w_state_d      = r_state;
        w_data0_d      = r_data0;
        w_cmderr_d     = r_cmderr;
        w_busy_d       = r_busy;
        w_is_write_d   = r_is_write;
        w_gpr_idx_d    = r_gpr_idx;
        w_resp_rdata_d = r_resp_rdata;
        w_resp_err_d   = r_resp_err;
        case (r_state)
            StIdle: begin
                if (req_valid) begin
                    w_state_d      = StResp;
                    w_resp_rdata_d = '0;
                    w_resp_err_d   = 1'b0;
                    w_busy_d       = 1'b0;
                    case (req_op)
                        OpRead: begin
                            if (w_is_data0) begin
                                w_resp_rdata_d = r_data0;
                            end else if (w_is_abscs) begin
                                w_resp_rdata_d = w_abscs;
                            end
                        end
                        OpWrite: begin
                            if (w_is_data0) begin
                                w_data0_d = req_wdata;
                            end else if (w_is_abscs) begin
                                w_cmderr_d = r_cmderr & ~req_wdata[AbscsCmderrMsb:AbscsCmderrLsb];
                            end else if (w_is_cmd) begin
                                w_cmderr_d = w_new_cmderr;
                                if (w_do_access) begin
                                    w_state_d    = StAccess;
                                    w_busy_d     = 1'b1;
                                    w_is_write_d = w_dec_write;
                                    w_gpr_idx_d  = w_dec_idx;
                                end
                            end
                        end
                        OpRsvd:  w_resp_err_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            StAccess: begin
                if (!r_is_write) begin
                    w_data0_d = gpr_rdata_i;
                end
                w_state_d = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    w_state_d = StIdle;
                    w_busy_d  = 1'b0;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_data0      <= '0;
            r_cmderr     <= CmdErrNone;
            r_busy       <= 1'b0;
            r_is_write   <= 1'b0;
            r_gpr_idx    <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_data0      <= w_data0_d;
            r_cmderr     <= w_cmderr_d;
            r_busy       <= w_busy_d;
            r_is_write   <= w_is_write_d;
            r_gpr_idx    <= w_gpr_idx_d;
            r_resp_rdata <= w_resp_rdata_d;
            r_resp_err   <= w_resp_err_d;
        end
    end

endmodule

// File: tb/tb_jtag_gpr_access.sv
// Scoreboard bench for jtag_gpr_access: directed DMI requests push expected responses,
// a negedge monitor pops and compares them and tallies GPR write pulses.
module tb_jtag_gpr_access;

    localparam logic [5:0] A_DATA0 = 6'h04;
    localparam logic [5:0] A_ABSCS = 6'h16;
    localparam logic [5:0] A_CMD   = 6'h17;
    localparam logic [5:0] A_OTHER = 6'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        halted_i;
    logic        gpr_we_o;
    logic [4:0]  gpr_addr_o;
    logic [31:0] gpr_wdata_o;
    logic [31:0] gpr_rdata_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          we_cnt  = 0;
    logic [4:0]  we_addr;
    logic [31:0] we_wdata;

    always #5 clk = ~clk;

    // Register file model: only x7 holds a non-zero value; x0 reads zero.
    assign gpr_rdata_i = (gpr_addr_o == 5'd7) ? 32'h12345678 : 32'h0;

    jtag_gpr_access #(
        .DMI_ADDR_W (6),
        .DATA_W     (32),
        .GPR_NUM    (32),
        .REGNO_BASE (16'h1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .halted_i    (halted_i),
        .gpr_we_o    (gpr_we_o),
        .gpr_addr_o  (gpr_addr_o),
        .gpr_wdata_o (gpr_wdata_o),
        .gpr_rdata_i (gpr_rdata_i)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (gpr_we_o) begin
                we_cnt++;
                we_addr  = gpr_addr_o;
                we_wdata = gpr_wdata_o;
            end
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got rdata %h with empty scoreboard", resp_rdata);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", 32'(resp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic dmi(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int exp_lat, input int hold);
        int   n;
        exp_t e;
        e.rdata = er;
        e.err   = ee;
        sb_q.push_back(e);
        if (hold > 0) resp_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        n = 1;
        while (!resp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_rdata", resp_rdata, er);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        if (hold > 0) begin
            @(posedge clk); #1;
            check("bp_release", 32'(req_ready), 32'd1);
        end
        n = 0;
        while (!req_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int base;
        int n;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'd0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        halted_i   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_gpr_we", 32'(gpr_we_o), 32'd0);
        check("rst_gpr_addr", 32'(gpr_addr_o), 32'd0);
        check("rst_gpr_wdata", gpr_wdata_o, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        dmi(2'd1, A_DATA0, 32'h0, 32'h0, 1'b0, 1, 0);
        dmi(2'd1, A_ABSCS, 32'h0, 32'h1, 1'b0, 1, 0);

        // GPR write of x5
        dmi(2'd2, A_DATA0, 32'hDEADBEEF, 32'h0, 1'b0, 1, 0);
        base = we_cnt;
        dmi(2'd2, A_CMD, 32'h00231005, 32'h0, 1'b0, 2, 0);
        check("wr_we_pulses", 32'(we_cnt - base), 32'd1);
        check("wr_gpr_addr", 32'(we_addr), 32'd5);
        check("wr_gpr_wdata", we_wdata, 32'hDEADBEEF);
        dmi(2'd1, A_ABSCS, 32'h0, 32'h1, 1'b0, 1, 0);

        // GPR read of x7
        base = we_cnt;
        dmi(2'd2, A_CMD, 32'h00221007, 32'h0, 1'b0, 2, 0);
        dmi(2'd1, A_DATA0, 32'h0, 32'h12345678, 1'b0, 1, 0);
        check("rd_no_we", 32'(we_cnt - base), 32'd0);

        // Not halted: cmderr=4, later commands ignored until cleared
        halted_i = 1'b0;
        base = we_cnt;
        dmi(2'd2, A_CMD, 32'h00231003, 32'h0, 1'b0, 1, 0);
        dmi(2'd1, A_ABSCS, 32'h0, 32'h401, 1'b0, 1, 0);
        halted_i = 1'b1;
        dmi(2'd2, A_CMD, 32'h00231005, 32'h0, 1'b0, 1, 0);
        dmi(2'd1, A_ABSCS, 32'h0, 32'h401, 1'b0, 1, 0);
        check("halt_no_we", 32'(we_cnt - base), 32'd0);
        dmi(2'd2, A_ABSCS, 32'h700, 32'h0, 1'b0, 1, 0);
        dmi(2'd1, A_ABSCS, 32'h0, 32'h1, 1'b0, 1, 0);

        // Unsupported command type and out-of-range regno
        base = we_cnt;
        dmi(2'd2, A_CMD, 32'h01231005, 32'h0, 1'b0, 1, 0);
        dmi(2'd1, A_ABSCS, 32'h0, 32'h201, 1'b0, 1, 0);
        dmi(2'd2, A_ABSCS, 32'h700, 32'h0, 1'b0, 1, 0);
        dmi(2'd2, A_CMD, 32'h00231020, 32'h0, 1'b0, 1, 0);
        dmi(2'd1, A_ABSCS, 32'h0, 32'h201, 1'b0, 1, 0);
        dmi(2'd2, A_ABSCS, 32'h700, 32'h0, 1'b0, 1, 0);
        check("notsup_no_we", 32'(we_cnt - base), 32'd0);

        // Reserved op, nop, write-only COMMAND, unmapped address
        dmi(2'd3, A_DATA0, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0);
        dmi(2'd0, A_DATA0, 32'h0, 32'h0, 1'b0, 1, 0);
        dmi(2'd1, A_CMD, 32'h0, 32'h0, 1'b0, 1, 0);
        dmi(2'd2, A_OTHER, 32'h55AA55AA, 32'h0, 1'b0, 1, 0);
        dmi(2'd1, A_OTHER, 32'h0, 32'h0, 1'b0, 1, 0);

        // Backpressure on a DATA0 read (DATA0 survived the op-3 request)
        dmi(2'd1, A_DATA0, 32'h0, 32'h12345678, 1'b0, 1, 3);

        // x0 read returns zero
        dmi(2'd2, A_CMD, 32'h00221000, 32'h0, 1'b0, 2, 0);
        dmi(2'd1, A_DATA0, 32'h0, 32'h0, 1'b0, 1, 0);

        // Reset during the ACCESS cycle of a write
        dmi(2'd2, A_DATA0, 32'hCAFEF00D, 32'h0, 1'b0, 1, 0);
        base      = we_cnt;
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_addr  = A_CMD;
        req_wdata = 32'h00231009;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        check("abort_we_high", 32'(gpr_we_o), 32'd1);
        check("abort_addr", 32'(gpr_addr_o), 32'd9);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_we_low", 32'(gpr_we_o), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_we_pulses", 32'(we_cnt - base), 32'd1);
        dmi(2'd1, A_DATA0, 32'h0, 32'h0, 1'b0, 1, 0);
        dmi(2'd1, A_ABSCS, 32'h0, 32'h1, 1'b0, 1, 0);

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
